// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types plus the line-fill additions (tag, fill FSM
// states, words per line).
package lc3b_types;
  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;
  typedef logic [2:0]   lc3b_c_offset;
  typedef logic [11:0]  lc3b_line_tag;

  localparam int LINE_WORDS = 8;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    DONE
  } fill_state;
endpackage

// File: rtl/word_insert.sv
// Replaces one 16-bit slot of a cache line; write-side dual of word select.
module word_insert
  import lc3b_types::*;
(
  input  lc3b_line     line,
  input  lc3b_c_offset offset,
  input  lc3b_word     word,
  output lc3b_line     merged
);

  for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_slot
    localparam lc3b_c_offset SLOT = lc3b_c_offset'(gi);
    assign merged[16*gi +: 16] = (offset == SLOT) ? word : line[16*gi +: 16];
  end

endmodule

// File: rtl/line_fill_buffer.sv
// Builds a 128-bit line from eight 16-bit memory beats, critical word first
// with wrap-around, and forwards the requested word as soon as it arrives.
module line_fill_buffer
  import lc3b_types::*;
#(
  parameter int CRIT_FIRST = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         fill_req,
  input  lc3b_word     fill_addr,
  output logic         fill_busy,
  output logic         crit_valid,
  output lc3b_word     crit_word,
  output logic         line_valid,
  output logic         line_ready,
  output lc3b_line     line,
  output lc3b_line_tag line_tag,
  output logic         mem_read,
  output lc3b_word     mem_address,
  input  lc3b_word     mem_rdata,
  input  logic         mem_resp
);

  fill_state    state_reg, state_next;
  lc3b_c_offset start_reg, start_next;
  lc3b_c_offset cnt_reg, cnt_next;
  lc3b_line_tag tag_reg, tag_next;
  lc3b_line     line_reg, line_next;
  lc3b_line     merged;
  lc3b_word     crit_word_reg, crit_word_next;
  logic         mem_read_reg, mem_read_next;
  logic         crit_valid_reg, crit_valid_next;
  logic         line_ready_reg, line_ready_next;
  lc3b_c_offset word_idx;
  logic         unused_addr_lsb;

  // Byte-address bit 0 never selects a word.
  assign unused_addr_lsb = fill_addr[0];

  // 3-bit add gives the mod-8 wrap for free.
  assign word_idx = start_reg + cnt_reg;

  word_insert u_insert (
    .line   (line_reg),
    .offset (word_idx),
    .word   (mem_rdata),
    .merged (merged)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      start_reg      <= '0;
      cnt_reg        <= '0;
      tag_reg        <= '0;
      line_reg       <= '0;
      crit_word_reg  <= '0;
      mem_read_reg   <= 1'b0;
      crit_valid_reg <= 1'b0;
      line_ready_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      start_reg      <= start_next;
      cnt_reg        <= cnt_next;
      tag_reg        <= tag_next;
      line_reg       <= line_next;
      crit_word_reg  <= crit_word_next;
      mem_read_reg   <= mem_read_next;
      crit_valid_reg <= crit_valid_next;
      line_ready_reg <= line_ready_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    start_next      = start_reg;
    cnt_next        = cnt_reg;
    tag_next        = tag_reg;
    line_next       = line_reg;
    crit_word_next  = crit_word_reg;
    mem_read_next   = mem_read_reg;
    crit_valid_next = 1'b0;
    line_ready_next = line_ready_reg;

    case (state_reg)
      IDLE: begin
        if (fill_req) begin
          tag_next        = fill_addr[15:4];
          start_next      = (CRIT_FIRST != 0) ? fill_addr[3:1] : '0;
          cnt_next        = '0;
          line_ready_next = 1'b0;
          mem_read_next   = 1'b1;
          state_next      = BURST;
        end
      end
      BURST: begin
        if (mem_resp) begin
          line_next = merged;
          cnt_next  = cnt_reg + 3'd1;
          if (cnt_reg == '0) begin
            crit_valid_next = 1'b1;
            crit_word_next  = mem_rdata;
          end
          // Last beat: line_ready rises together with the DONE pulse.
          if (cnt_reg == 3'(LINE_WORDS - 1)) begin
            mem_read_next   = 1'b0;
            line_ready_next = 1'b1;
            state_next      = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign fill_busy   = (state_reg != IDLE);
  assign line_valid  = (state_reg == DONE);
  assign line_ready  = line_ready_reg;
  assign crit_valid  = crit_valid_reg;
  assign crit_word   = crit_word_reg;
  assign line        = line_reg;
  assign line_tag    = tag_reg;
  assign mem_read    = mem_read_reg;
  assign mem_address = {tag_reg, word_idx, 1'b0};

endmodule

// File: tb/tb_line_fill_buffer.sv
// Scoreboard bench: one CRIT_FIRST=0 and one CRIT_FIRST=1 instance run in
// lockstep against a cycle-level reference model of the fill protocol.
module tb_line_fill_buffer;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         fill_req = 1'b0;
  logic [15:0]  fill_addr = '0;
  logic         mem_resp = 1'b0;
  logic         force_resp = 1'b0;

  logic         fill_busy0, crit_valid0, line_valid0, line_ready0, mem_read0;
  logic [15:0]  crit_word0, mem_address0, mem_rdata0;
  logic [127:0] line0;
  logic [11:0]  line_tag0;
  logic         fill_busy1, crit_valid1, line_valid1, line_ready1, mem_read1;
  logic [15:0]  crit_word1, mem_address1, mem_rdata1;
  logic [127:0] line1;
  logic [11:0]  line_tag1;

  line_fill_buffer #(.CRIT_FIRST(0)) u_dut0 (
    .clk(clk), .reset(reset), .fill_req(fill_req), .fill_addr(fill_addr),
    .fill_busy(fill_busy0), .crit_valid(crit_valid0), .crit_word(crit_word0),
    .line_valid(line_valid0), .line_ready(line_ready0), .line(line0),
    .line_tag(line_tag0), .mem_read(mem_read0), .mem_address(mem_address0),
    .mem_rdata(mem_rdata0), .mem_resp(mem_resp)
  );

  line_fill_buffer #(.CRIT_FIRST(1)) u_dut1 (
    .clk(clk), .reset(reset), .fill_req(fill_req), .fill_addr(fill_addr),
    .fill_busy(fill_busy1), .crit_valid(crit_valid1), .crit_word(crit_word1),
    .line_valid(line_valid1), .line_ready(line_ready1), .line(line1),
    .line_tag(line_tag1), .mem_read(mem_read1), .mem_address(mem_address1),
    .mem_rdata(mem_rdata1), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] a0; logic [15:0] a1; } beat_t;
  typedef struct { int cyc; logic [15:0] w0; logic [15:0] w1; } crit_t;
  typedef struct { int cyc; logic [127:0] data; logic [11:0] tag; } line_t;

  beat_t beat_q[$];
  crit_t crit_q[$];
  line_t line_q[$];

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  // Reference model state
  bit           active = 1'b0;
  int           acc_cyc = 0;
  int           done_cyc = 0;
  int           acc_count = 0;
  logic [15:0]  next_base = '0;
  logic [15:0]  cur_base = '0;
  int           next_w = 0;
  int           cur_w = 0;
  logic [127:0] hold_line = '0;
  logic [127:0] pend_line = '0;
  logic [11:0]  hold_tag = '0;
  logic [11:0]  pend_tag = '0;
  bit           exp_ready = 1'b0;

  // Memory returns base + word index of the addressed word.
  assign mem_rdata0 = cur_base + {13'd0, mem_address0[3:1]};
  assign mem_rdata1 = cur_base + {13'd0, mem_address1[3:1]};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory responder: answers each beat after cur_w wait cycles.
  initial begin
    int  wcnt;
    bit  resp;
    wcnt = 0;
    forever begin
      @(posedge clk);
      #2;
      resp = 1'b0;
      if (mem_read0 && !reset) begin
        if (wcnt >= cur_w) begin
          resp = 1'b1;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
      mem_resp = resp | force_resp;
    end
  end

  // Monitor + reference model, sampled mid-cycle.
  bit busy_win, in_burst;
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_line0", line0, 128'd0);
      chk("rst_line1", line1, 128'd0);
      chk("rst_ctrl0", 128'({line_tag0, mem_address0, crit_word0, mem_read0,
                             crit_valid0, line_valid0, line_ready0, fill_busy0}), 128'd0);
      chk("rst_ctrl1", 128'({line_tag1, mem_address1, crit_word1, mem_read1,
                             crit_valid1, line_valid1, line_ready1, fill_busy1}), 128'd0);
      beat_q.delete();
      crit_q.delete();
      line_q.delete();
      active    = 1'b0;
      exp_ready = 1'b0;
      hold_line = '0;
      hold_tag  = '0;
    end else begin
      busy_win = active && cyc > acc_cyc && cyc <= done_cyc;
      in_burst = active && cyc > acc_cyc && cyc < done_cyc;
      chk("mem_read", 128'({mem_read1, mem_read0}), 128'({in_burst, in_burst}));
      chk("fill_busy", 128'({fill_busy1, fill_busy0}), 128'({busy_win, busy_win}));
      if (in_burst) begin
        chk("ready_low_in_burst", 128'({line_ready1, line_ready0}), 128'd0);
      end else if (!busy_win) begin
        chk("ready_idle", 128'({line_ready1, line_ready0}), 128'({exp_ready, exp_ready}));
        chk("hold_line0", line0, hold_line);
        chk("hold_line1", line1, hold_line);
        chk("hold_tag", 128'({line_tag1, line_tag0}), 128'({hold_tag, hold_tag}));
      end

      if (mem_read0 && mem_resp) begin
        if (beat_q.size() == 0) begin
          chk("beat_unexpected", 128'(mem_address0), 128'd0);
        end else begin
          beat_t b;
          b = beat_q.pop_front();
          chk("addr_cf0", 128'(mem_address0), 128'(b.a0));
          chk("addr_cf1", 128'(mem_address1), 128'(b.a1));
        end
      end

      if (crit_valid0 || crit_valid1) begin
        if (crit_q.size() == 0) begin
          chk("crit_unexpected", 128'({crit_valid1, crit_valid0}), 128'd0);
        end else begin
          crit_t c;
          c = crit_q.pop_front();
          chk("crit_both", 128'({crit_valid1, crit_valid0}), 128'(2'b11));
          chk("crit_cycle", 128'(cyc), 128'(c.cyc));
          chk("crit_word0", 128'(crit_word0), 128'(c.w0));
          chk("crit_word1", 128'(crit_word1), 128'(c.w1));
        end
      end

      if (line_valid0 || line_valid1) begin
        if (line_q.size() == 0) begin
          chk("line_unexpected", 128'({line_valid1, line_valid0}), 128'd0);
        end else begin
          line_t l;
          l = line_q.pop_front();
          chk("line_valid_both", 128'({line_valid1, line_valid0}), 128'(2'b11));
          chk("line_cycle", 128'(cyc), 128'(l.cyc));
          chk("line0", line0, l.data);
          chk("line1", line1, l.data);
          chk("line_tag", 128'({line_tag1, line_tag0}), 128'({l.tag, l.tag}));
        end
      end

      if (active && cyc == done_cyc) begin
        active    = 1'b0;
        hold_line = pend_line;
        hold_tag  = pend_tag;
        exp_ready = 1'b1;
      end

      if (fill_req && !busy_win) begin
        beat_t b;
        crit_t c;
        line_t l;
        logic [2:0] k;
        active   = 1'b1;
        acc_cyc  = cyc;
        cur_w    = next_w;
        cur_base = next_base;
        done_cyc = cyc + 1 + 8 * (cur_w + 1);
        pend_tag = fill_addr[15:4];
        for (int i = 0; i < 8; i++) begin
          k = fill_addr[3:1] + 3'(i);
          b.a0 = {fill_addr[15:4], 3'(i), 1'b0};
          b.a1 = {fill_addr[15:4], k, 1'b0};
          beat_q.push_back(b);
          pend_line[16*i +: 16] = cur_base + 16'(i);
        end
        c.cyc = cyc + 2 + cur_w;
        c.w0  = cur_base;
        c.w1  = cur_base + {13'd0, fill_addr[3:1]};
        crit_q.push_back(c);
        l.cyc  = done_cyc;
        l.data = pend_line;
        l.tag  = pend_tag;
        line_q.push_back(l);
        acc_count++;
        $display("cycle %0d: fill accepted addr=%h base=%h wait=%0d", cyc, fill_addr, cur_base, cur_w);
      end
    end
  end

  task automatic issue_fill(input logic [15:0] addr, input logic [15:0] base,
                            input int w, input bit stray);
    int n;
    n          = acc_count;
    fill_addr  = addr;
    next_base  = base;
    next_w     = w;
    fill_req   = 1'b1;
    force_resp = stray;
    for (int i = 0; i < 300 && acc_count == n; i++) tick();
    fill_req   = 1'b0;
    force_resp = 1'b0;
    chk("accept", 128'(acc_count - n), 128'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && active; i++) tick();
    chk("idle_reached", 128'(active), 128'd0);
    tick();
  endtask

  initial begin
    #1 reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    issue_fill(16'h1236, 16'hA000, 0, 1'b0);
    wait_idle();
    issue_fill(16'h1236, 16'hA000, 3, 1'b0);
    wait_idle();
    issue_fill(16'h40AE, 16'h3C18, 1, 1'b0);
    wait_idle();

    // Request during BURST must be dropped, not queued.
    issue_fill(16'h2222, 16'h7770, 1, 1'b0);
    repeat (3) tick();
    fill_addr = 16'h5550;
    fill_req  = 1'b1;
    tick();
    fill_req  = 1'b0;
    wait_idle();
    repeat (4) tick();

    // Reset after the fourth beat, then a stray response.
    issue_fill(16'h3338, 16'hB100, 0, 1'b0);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset      = 1'b0;
    force_resp = 1'b1;
    tick();
    force_resp = 1'b0;
    tick();
    issue_fill(16'h0010, 16'h5550, 2, 1'b1);
    wait_idle();

    // fill_req held high: back-to-back fills.
    fill_addr = 16'h6E4A;
    next_w    = 0;
    fill_req  = 1'b1;
    for (int i = 0; i < 35; i++) begin
      next_base = 16'($urandom);
      tick();
    end
    fill_req = 1'b0;
    wait_idle();

    repeat (10) begin
      issue_fill(16'($urandom), 16'($urandom), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)));
      wait_idle();
      repeat ($urandom_range(0, 2)) tick();
    end

    chk("beat_q_drained", 128'(beat_q.size()), 128'd0);
    chk("crit_q_drained", 128'(crit_q.size()), 128'd0);
    chk("line_q_drained", 128'(line_q.size()), 128'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/line_fill_buffer.md
Name: line_fill_buffer

Overview:
- Assembles one 128-bit cache line from eight sequential 16-bit reads on the narrow physical-memory bus.
- Sits directly upstream of the word-select stage. Its line output feeds that stage's line input; the requested word offset feeds its offset input.
- Fetches critical-word-first with wrap-around. Forwards the critical word early so the pipeline can restart before the line completes.

Parameters:
- CRIT_FIRST, 1, 1 = burst starts at the requested word and wraps mod 8; 0 = burst always starts at word 0.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- fill_req  in  1  request a line fill; sampled only in IDLE
- fill_addr  in  16 (lc3b_word)  byte address of the missing word
- fill_busy  out  1  high in BURST and DONE
- crit_valid  out  1  one-cycle pulse when the requested word arrives
- crit_word  out  16 (lc3b_word)  requested word; valid with crit_valid
- line_valid  out  1  one-cycle pulse when all 8 words are captured
- line_ready  out  1  level; high from DONE until the next fill is accepted
- line  out  128 (lc3b_line)  line register; word k occupies bits [16k+15:16k]
- line_tag  out  12  fill_addr[15:4] of the current or last fill
- mem_read  out  1  memory read strobe
- mem_address  out  16 (lc3b_word)  word-aligned read address
- mem_rdata  in  16 (lc3b_word)  memory read data
- mem_resp  in  1  memory beat-complete strobe

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE.
  - All outputs 0: line=0, line_tag=0, mem_read=0, mem_address=0, crit_valid=0, line_valid=0, line_ready=0, fill_busy=0.
  - beat counter=0.
  - A fill in progress is abandoned. mem_resp arriving after reset is ignored.
- States are IDLE, BURST and DONE.
- IDLE:
  - If fill_req=1: latch line_tag<=fill_addr[15:4] and start<=(CRIT_FIRST ? fill_addr[3:1] : 0); set cnt<=0, line_ready<=0; go to BURST.
  - mem_resp is ignored. fill_req=0 leaves all state held.
- BURST:
  - mem_read=1 continuously across all beats (registered; first high the cycle after acceptance).
  - Current word index k = (start + cnt) mod 8 (3-bit wrap).
  - mem_address = {line_tag, k, 1'b0}.
  - On mem_resp=1:
    - line[16k+15:16k] <= mem_rdata; other words unchanged.
    - If cnt==0: crit_valid pulses the next cycle with crit_word=mem_rdata. This is the word at fill_addr when CRIT_FIRST=1 and word 0 when CRIT_FIRST=0.
    - cnt <= cnt+1; mem_address advances the next cycle.
    - If cnt==7: go to DONE and drop mem_read the next cycle.
  - No mem_resp means hold (unbounded wait states).
  - fill_req in BURST or DONE is ignored and not queued.
- DONE (exactly 1 cycle): line_valid=1, line_ready<=1, fill_busy=1; then go to IDLE.
- Line contents:
  - Updated in place per beat, so partial contents are visible during BURST. Consumers qualify with line_ready/line_valid.
  - After DONE, line holds until the next accepted fill overwrites it beat by beat. line_ready drops on acceptance.
- Latency with zero-wait memory (mem_resp every BURST cycle):
  - acceptance at cycle 0; mem_read high cycles 1–8; crit_valid at cycle 2; line_valid at cycle 9.
- Back-to-back fills: fill_req held high re-accepts on the first IDLE cycle after DONE (minimum 10 cycles between acceptances).
- Simultaneous fill_req and mem_resp in IDLE: the fill is accepted and the resp is ignored.

Decomposition:
- lc3b_types package gains:
  - lc3b_line_tag (12 bits)
  - fill_state enum {IDLE, BURST, DONE}
  - constant LINE_WORDS=8
- lc3b_word, lc3b_line and lc3b_c_offset are reused.
- One combinational sub-module, word_insert: inputs line, offset, word; output is line with that slot replaced.
  - It is the write-side dual of the word-select stage. Reused later for store merging.

Test Plan:
- Zero-wait fill, fill_addr=0x1236, CRIT_FIRST=1, mem_rdata=0xA000+word index -> mem_address sequence 0x1236,0x1238,0x123A,0x123C,0x123E,0x1230,0x1232,0x1234; crit_valid at cycle 2 with 0xA003; line_valid at cycle 9; line=0xA007_A006_…_A000; line_tag=0x123.
- Same fill with 3 wait cycles per beat -> each beat's address held for 4 cycles; line_valid exactly 32 cycles after mem_read rises; mem_read never drops mid-burst.
- CRIT_FIRST=0, fill_addr=0x40AE -> addresses 0x40A0..0x40AE ascending; crit_word=word 0.
- fill_req pulsed during BURST with a different address -> ignored; line_tag unchanged; no second burst starts after DONE unless fill_req is asserted in IDLE.
- reset asserted after the 4th beat -> all outputs 0 in the same cycle; a stray mem_resp the following cycle causes no change; a new fill_req=0x0010 then completes a normal 8-beat fill.
- fill_req held high continuously -> fills accepted every 10 cycles under zero-wait memory; line_ready low from each acceptance until its DONE.
